uart_rx_frame: RTL and testbench

Parametrised UART receiver with runtime baud divisor, selectable parity and stop bits, 3-sample majority voting, error reporting and a valid/ready output holding register. It sits between the board UART pin and the command/byte parser in the DDR3 test design. It also replaces the fixed-table 8N1 receiver wherever a configurable or error-checked link is needed.

---
 rtl/uart_rx_frame_if.sv | 33 +++
 rtl/uart_rx_frame.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_if.sv
// Receive-side output bundle of uart_rx_frame: held word, error flags
// and the valid/ready handshake towards the byte parser.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] out_data;
  logic                 out_vld;
  logic                 out_rdy;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 overrun;

  modport master (
    output out_data,
    output out_vld,
    output parity_err,
    output frame_err,
    output break_det,
    output overrun,
    input  out_rdy
  );

  modport slave (
    input  out_data,
    input  out_vld,
    input  parity_err,
    input  frame_err,
    input  break_det,
    input  overrun,
    output out_rdy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receiver: runtime baud divisor, parity/stop selection,
// 3-sample majority vote, error flags and a valid/ready holding register.
module uart_rx_frame #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  uart_rx_frame_if.master  out_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e state_q, state_d;

  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             par_en_q, par_en_d;
  logic             par_odd_q, par_odd_d;
  logic             stop2_q, stop2_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic             s0_q, s0_d;
  logic             s1_q, s1_d;
  logic             pbit_q, pbit_d;
  logic             ferr_q, ferr_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             perr_q, perr_d;
  logic             fe_q, fe_d;
  logic             brk_q, brk_d;
  logic             ovr_q, ovr_d;

  logic             fall;
  logic [DIV_W-1:0] half;
  logic             wrap, at_hm1, at_h, at_hp1;
  logic             vote;
  logic             done;
  logic             fin_ferr;
  logic             par_x;
  logic             new_perr, new_brk;

  assign fall   = rx_prev_q & ~rx_s_q;
  assign half   = div_q >> 1;
  assign wrap   = cnt_q == div_q - DIV_W'(1);
  assign at_hm1 = cnt_q == half - DIV_W'(1);
  assign at_h   = cnt_q == half;
  assign at_hp1 = cnt_q == half + DIV_W'(1);
  assign vote   = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    pbit_d    = pbit_q;
    ferr_d    = ferr_q;
    fin_ferr  = ferr_q;
    done      = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
      if (at_hm1) s0_d = rx_s_q;
      if (at_h)   s1_d = rx_s_q;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d   = S_START;
          div_d     = baud_div;
          par_en_d  = (parity_mode == 2'd1) || (parity_mode == 2'd2);
          par_odd_d = parity_mode == 2'd2;
          stop2_d   = stop2;
          ferr_d    = 1'b0;
          bitcnt_d  = '0;
        end
      end
      S_START: begin
        if (at_hp1 && vote) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (wrap) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (at_hp1) begin
          shreg_d  = {vote, shreg_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 4'd1;
        end
        if (wrap && bitcnt_q == 4'(DATA_BITS)) begin
          bitcnt_d = '0;
          state_d  = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (at_hp1) pbit_d = vote;
        if (wrap)   state_d = S_STOP;
      end
      S_STOP: begin
        if (at_hp1) begin
          fin_ferr = ferr_q | ~vote;
          ferr_d   = fin_ferr;
          // first of two stop bits: keep going to the second
          if (stop2_q && bitcnt_q == 4'd0) begin
            bitcnt_d = 4'd1;
          end else begin
            done    = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign par_x    = ^shreg_q ^ pbit_q;
  assign new_perr = par_en_q & (par_odd_q ? ~par_x : par_x);
  assign new_brk  = fin_ferr & (shreg_q == '0) & (~par_en_q | ~pbit_q);

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    perr_d = perr_q;
    fe_d   = fe_q;
    brk_d  = brk_q;
    ovr_d  = 1'b0;
    if (done) begin
      if (!vld_q || out_if.out_rdy) begin
        data_d = shreg_q;
        perr_d = new_perr;
        fe_d   = fin_ferr;
        brk_d  = new_brk;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && out_if.out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      pbit_q    <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      perr_q    <= 1'b0;
      fe_q      <= 1'b0;
      brk_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      pbit_q    <= pbit_d;
      ferr_q    <= ferr_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      perr_q    <= perr_d;
      fe_q      <= fe_d;
      brk_q     <= brk_d;
      ovr_q     <= ovr_d;
    end
  end

  assign out_if.out_data   = data_q;
  assign out_if.out_vld    = vld_q;
  assign out_if.parity_err = perr_q;
  assign out_if.frame_err  = fe_q;
  assign out_if.break_det  = brk_q;
  assign out_if.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: vector table of frames plus hand-built
// sequences for latency, glitch, break, overrun and reset.
module tb_uart_rx_frame;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic [15:0] baud_div = 16'd16;
  logic [1:0]  parity_mode = 2'd0;
  logic        stop2 = 1'b0;

  uart_rx_frame_if #(.DATA_BITS(8)) ifc ();

  uart_rx_frame #(.DATA_BITS(8), .DIV_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .out_if      (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    logic       pb;
    logic       s2;
    logic       st1;
    logic       st2;
    int         div;
    logic       pe;
    logic       fe;
    logic       bk;
  } vec_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   rise_cyc = 0;
  int   rise_cnt = 0;
  int   ovr_cnt = 0;
  logic prev_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      if (ifc.overrun) ovr_cnt++;
      if (ifc.out_vld && !prev_vld) begin
        rise_cyc = cyc;
        rise_cnt++;
      end
      prev_vld = ifc.out_vld;
      if (ifc.out_vld && ifc.out_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(ifc.out_data), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(ifc.out_data), 32'(e.d));
          chk("parity_err", 32'(ifc.parity_err), 32'(e.pe));
          chk("frame_err", 32'(ifc.frame_err), 32'(e.fe));
          chk("break_det", 32'(ifc.break_det), 32'(e.bk));
        end
      end
    end
  end

  task automatic line(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] pm,
                      input logic pb, input logic s2, input logic st1,
                      input logic st2, input int div);
    baud_div    = 16'(div);
    parity_mode = pm;
    stop2       = s2;
    uart_rx     = 1'b0;
    t0          = cyc;
    repeat (4) @(negedge clk);
    // config pins wiggle mid-frame; the frame must keep its latched copy
    baud_div    = 16'(div + 3);
    parity_mode = ~pm;
    stop2       = ~s2;
    repeat (div - 4) @(negedge clk);
    for (int i = 0; i < 8; i++) line(d[i], div);
    if (pm == 2'd1 || pm == 2'd2) line(pb, div);
    line(st1, div);
    if (s2) line(st2, div);
    uart_rx = 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input logic pe,
                      input logic fe, input logic bk);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.bk = bk;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int k = 0;
    while (sb.size() != 0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[12];

  initial begin
    int r0, o0;
    tbl[0]  = '{8'h37, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 20, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{8'h37, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 20, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'h37, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 20, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'h37, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 20, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{8'h81, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{8'h3C, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1,  8, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{8'h96, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 12, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8'h5A, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{8'h00, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{8'hFF, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 255, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{8'h00, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0,  9, 1'b0, 1'b1, 1'b0};

    ifc.out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_data", 32'(ifc.out_data), 32'd0);
    chk("rst_out_vld", 32'(ifc.out_vld), 32'd0);
    chk("rst_parity_err", 32'(ifc.parity_err), 32'd0);
    chk("rst_frame_err", 32'(ifc.frame_err), 32'd0);
    chk("rst_break_det", 32'(ifc.break_det), 32'd0);
    chk("rst_overrun", 32'(ifc.overrun), 32'd0);
    rst = 1'b0;
    line(1'b1, 10);

    // 8N1 latency: start edge to out_vld rise
    push(8'hA5, 1'b0, 1'b0, 1'b0);
    send(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
    line(1'b1, 32);
    wait_drain("drain_a5", 100);
    chk("latency_a5", 32'(rise_cyc - t0), 32'd157);

    for (int i = 0; i < 12; i++) begin
      push(tbl[i].d, tbl[i].pe, tbl[i].fe, tbl[i].bk);
      send(tbl[i].d, tbl[i].pm, tbl[i].pb, tbl[i].s2,
           tbl[i].st1, tbl[i].st2, tbl[i].div);
      line(1'b1, 2 * tbl[i].div);
      wait_drain($sformatf("drain_vec%0d", i), 600);
    end

    // short glitch is rejected as a false start
    baud_div = 16'd16; parity_mode = 2'd0; stop2 = 1'b0;
    r0 = rise_cnt;
    line(1'b0, 3);
    line(1'b1, 48);
    chk("glitch_no_vld", 32'(rise_cnt - r0), 32'd0);
    push(8'h5A, 1'b0, 1'b0, 1'b0);
    send(8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
    line(1'b1, 32);
    wait_drain("drain_glitch", 100);

    // break: line low for 12 bit times
    baud_div = 16'd16; parity_mode = 2'd0; stop2 = 1'b0;
    push(8'h00, 1'b0, 1'b1, 1'b1);
    line(1'b0, 12 * 16);
    line(1'b1, 32);
    wait_drain("drain_break", 100);

    // overrun: consumer stalled across two back-to-back frames
    ifc.out_rdy = 1'b0;
    o0 = ovr_cnt;
    push(8'h11, 1'b0, 1'b0, 1'b0);
    send(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
    send(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
    line(1'b1, 32);
    chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_held_data", 32'(ifc.out_data), 32'h11);
    chk("ovr_held_vld", 32'(ifc.out_vld), 32'd1);
    ifc.out_rdy = 1'b1;
    wait_drain("drain_ovr", 20);
    #2;
    chk("ovr_vld_clear", 32'(ifc.out_vld), 32'd0);
    @(negedge clk);

    // reset mid-frame while a word is held
    ifc.out_rdy = 1'b0;
    send(8'h66, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
    line(1'b1, 16);
    chk("pre_rst_vld", 32'(ifc.out_vld), 32'd1);
    chk("pre_rst_data", 32'(ifc.out_data), 32'h66);
    r0 = rise_cnt;
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) line(1'b0, 16);
    line(1'b1, 8);
    rst = 1'b1;
    line(1'b1, 3);
    chk("mid_rst_data", 32'(ifc.out_data), 32'd0);
    chk("mid_rst_vld", 32'(ifc.out_vld), 32'd0);
    chk("mid_rst_flags", 32'({ifc.parity_err, ifc.frame_err,
                              ifc.break_det, ifc.overrun}), 32'd0);
    rst = 1'b0;
    ifc.out_rdy = 1'b1;
    line(1'b1, 5 + 3 * 16 + 16 + 32);
    chk("rst_no_vld", 32'(rise_cnt - r0), 32'd0);
    push(8'hC3, 1'b0, 1'b0, 1'b0);
    send(8'hC3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
    line(1'b1, 32);
    wait_drain("drain_c3", 100);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
